mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer for the single-port 1024x32
//  data memory. Accepts word read/write requests over valid/ready handshakes,
//  and serialises them onto the memory's address/write_data/mem_write port.
//  Returns read data, or a write acknowledge, on a per-requester response channel.
//  Sits between the core datapath (requester 0) and an auxiliary/DMA engine
//  (requester 1) and the memory block.
// PARAMETERS
//  ADDR_W  10  word address width (1024 words)
//  DATA_W  32  data word width
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       synchronous active-low reset
//  req0_valid     in   1       requester 0 request valid
//  req0_ready     out  1       requester 0 request accepted this cycle
//  req0_we        in   1       1=write, 0=read
//  req0_addr      in   ADDR_W word address
//  req0_wdata     in   DATA_W write data
//  rsp0_valid     out  1       response to requester 0 valid
//  rsp0_ready     in   1       requester 0 takes response
//  rsp0_rdata     out  DATA_W read data (0 for write ack)
//  req1_*/rsp1_*  --   --      identical set for requester 1
//  mem_address    out  ADDR_W to memory address
//  mem_write_data out  DATA_W to memory write_data
//  mem_write      out  1       to memory mem_write
//  mem_read_data  in   DATA_W from memory read_data (registered, 1-cycle)
//  busy           out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - One clock, clk; rst_n synchronous active-low. All state updates on posedge clk.
//  - FSM states: IDLE -> ISSUE -> (read) RDWAIT -> RESP -> IDLE; (write) ISSUE -> RESP.
//  - IDLE: if any reqN_valid, grant one; reqN_ready=1 combinationally for the
//    granted requester only. Latch we/addr/wdata and owner id; go to ISSUE.
//  - Round-robin: both valid -> grant the requester not granted last; one valid
//    -> grant it. last_grant updates only on an accepted request.
//  - ISSUE: mem_address=addr_q, mem_write_data=wdata_q, mem_write=we_q & rst_n.
//    A write commits at the ISSUE->next edge.
//  - RDWAIT: mem_read_data is valid; capture it into rdata_q; go to RESP.
//  - RESP: rspN_valid=1 for the owner, rspN_rdata=rdata_q (write: 0); hold until
//    rspN_ready=1, then go to IDLE. No new request is accepted in RESP.
//  - Latency, accept edge = cycle 0: read rsp_valid in cycle 3, write ack in cycle 2.
//    Back-to-back throughput: one read per 4 cycles, one write per 3 cycles.
//  - mem_write=0 in every state except ISSUE. mem_address/mem_write_data hold
//    addr_q/wdata_q in all states; no X is driven.
//  - Reset values: state=IDLE, last_grant=1 (req0 wins first tie), all _q regs=0.
//    All ready/valid outputs=0, mem_write=0, busy=0.
//  - Reset mid-operation aborts the transaction. The response is dropped.
//    A write in ISSUE during a cycle with rst_n=0 is suppressed (mem_write gated by rst_n).
//  - Requesters hold valid/we/addr/wdata stable until ready; the arbiter does not check this.
//  - Response back-pressure: rsp_ready low holds RESP indefinitely. rdata stays stable.
// TESTING
//  1. Reset, then req0 write addr=0x005 data=0xDEADBEEF -> req0_ready cycle 0;
//     mem_write=1 only in cycle 1 with addr 0x005; rsp0_valid cycle 2, rdata=0.
//  2. req0 read 0x005 after test 1 -> mem_write=0 throughout; rsp0_valid cycle 3,
//     rsp0_rdata=0xDEADBEEF.
//  3. req0 and req1 both valid continuously (reads of 0x001/0x002) -> grants
//     alternate 0,1,0,1. The first grant goes to req0 after reset.
//  4. Read from req1 at 0x3FF with rsp1_ready low for 5 cycles -> rsp1_valid stays
//     high with stable data; busy=1; req0_ready stays 0 until rsp1_ready.
//  5. Write accepted, rst_n=0 during ISSUE -> mem_write=0 that cycle; next-cycle
//     outputs all at reset values; a later read of that address returns old data.
//  6. Only req1 valid, repeated -> req1 granted each time; no starvation wait.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port,
// registered-read word memory. Each accepted request walks
// IDLE -> ISSUE -> (RDWAIT) -> RESP and is answered on its owner's
// response channel before the next request is taken.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;

  logic                last_grant;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_valid;
  logic                grant_id;
  logic                accept;
  logic                owner_rsp_ready;

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    accept          = rst_n & (state == ST_IDLE) & any_valid;
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = we_q ? ST_RESP : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, read-data capture and registered busy flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      busy       <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        owner_q    <= grant_id;
        we_q       <= grant_id ? req1_we    : req0_we;
        addr_q     <= grant_id ? req1_addr  : req0_addr;
        wdata_q    <= grant_id ? req1_wdata : req0_wdata;
        rdata_q    <= '0;
      end
      if (state == ST_RDWAIT) begin
        rdata_q <= mem_read_data;
      end
      busy <= (state_next != ST_IDLE);
    end
  end

  // Handshake and memory-port outputs decoded from state
  always_comb begin
    req0_ready = accept & ~grant_id;
    req1_ready = accept & grant_id;
    mem_write  = (state == ST_ISSUE) & we_q & rst_n;
    rsp0_valid = (state == ST_RESP) & ~owner_q;
    rsp1_valid = (state == ST_RESP) & owner_q;
    rsp0_rdata = owner_q ? '0 : rdata_q;
    rsp1_rdata = owner_q ? rdata_q : '0;
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1024x32
// registered-read memory. Unwritten words read as {16'hC0DE, 6'h0, addr}.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req0_valid, req0_ready, req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid, rsp0_ready;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp1_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read_data(mem_read_data), .busy(busy)
  );

  // Behavioural memory: write on mem_write, registered read every cycle
  bit          written   [1024];
  logic [31:0] mem_store [1024];

  function automatic logic [31:0] default_word(input logic [9:0] a);
    return {16'hC0DE, 6'h00, a};
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      mem_store[mem_address] <= mem_write_data;
      written[mem_address]   <= 1'b1;
    end
    mem_read_data <= written[mem_address] ? mem_store[mem_address]
                                          : default_word(mem_address);
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one req0 read and return its response data ('x on timeout)
  task automatic req0_read(input logic [9:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = addr;
    #1;
    n = 0;
    while (!req0_ready && n < 10) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n = 0;
    while (!rsp0_valid && n < 10) begin @(negedge clk); #1; n++; end
    data = rsp0_valid ? rsp0_rdata : 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, busy, mem_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: rsp0v/rsp1v/busy/mem_write got %b want 0000",
               {rsp0_valid, rsp1_valid, busy, mem_write});
    end
    checks++;
    if (mem_address !== 10'h000 || mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_port: addr %h data %h want 000 00000000", mem_address, mem_write_data);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h005; req0_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({req0_ready, req1_ready, mem_write} !== 3'b100) begin
      errors++; $display("FAIL wr_c0: ready0/ready1/mem_write got %b want 100", {req0_ready, req1_ready, mem_write});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 10'h005 || mem_write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_c1_issue: we %b addr %h data %h want 1 005 deadbeef", mem_write, mem_address, mem_write_data);
    end
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_c1_flags: rsp0v %b busy %b want 0 1", rsp0_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL wr_c2_ack: rsp0v %b rdata %h we %b want 1 00000000 0", rsp0_valid, rsp0_rdata, mem_write);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_c3_idle: rsp0v %b busy %b want 0 0", rsp0_valid, busy);
    end
  endtask

  task automatic test_read();
    logic seen_we;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h005;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rd_c0_ready: got %b want 1", req0_ready);
    end
    seen_we = mem_write;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    seen_we = seen_we | mem_write;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL rd_c1_rsp: got %b want 0", rsp0_valid);
    end
    @(negedge clk);
    #1;
    seen_we = seen_we | mem_write;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL rd_c2_rsp: got %b want 0", rsp0_valid);
    end
    @(negedge clk);
    #1;
    seen_we = seen_we | mem_write;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_c3_data: rsp0v %b rdata %h want 1 deadbeef", rsp0_valid, rsp0_rdata);
    end
    checks++;
    if (seen_we !== 1'b0) begin
      errors++; $display("FAIL rd_no_write: mem_write seen %b want 0", seen_we);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h002;
    for (int i = 0; i < 4; i++) begin
      int g;
      int n;
      logic [31:0] got;
      logic [31:0] want;
      g = -1;
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 10) begin @(negedge clk); #1; n++; end
      if (req0_ready) g = 0;
      else if (req1_ready) g = 1;
      checks++;
      if (g != (i % 2)) begin
        errors++; $display("FAIL rr_grant%0d: got %0d want %0d", i, g, i % 2);
      end
      @(negedge clk);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 10) begin @(negedge clk); #1; n++; end
      got  = (i % 2 == 0) ? (rsp0_valid ? rsp0_rdata : 'x) : (rsp1_valid ? rsp1_rdata : 'x);
      want = (i % 2 == 0) ? 32'hC0DE0001 : 32'hC0DE0002;
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL rr_data%0d: got %h want %h", i, got, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] got;
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h3FF; rsp1_ready = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept: req1_ready got %b want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin
        errors++; $display("FAIL bp_pre_ready%0d: req0_ready got %b want 0", k, req0_ready);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hC0DE03FF || busy !== 1'b1 || req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rsp1v %b rdata %h busy %b ready0 %b want 1 c0de03ff 1 0",
                 k, rsp1_valid, rsp1_rdata, busy, req0_ready);
      end
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release: rsp1v %b ready0 %b want 1 0", rsp1_valid, req0_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after: rsp1v %b ready0 %b want 0 1", rsp1_valid, req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n = 0;
    while (!rsp0_valid && n < 10) begin @(negedge clk); #1; n++; end
    got = rsp0_valid ? rsp0_rdata : 'x;
    checks++;
    if (got !== 32'hC0DE0001) begin
      errors++; $display("FAIL bp_req0_data: got %h want c0de0001", got);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h010; req0_wdata = 32'hBAD0BAD0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL abort_accept: req0_ready got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL abort_gate: mem_write got %b want 0", mem_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, mem_write, req0_ready, req1_ready} !== 6'b000000 ||
        mem_address !== 10'h000 || mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: flags %b addr %h data %h want 000000 000 00000000",
               {busy, rsp0_valid, rsp1_valid, mem_write, req0_ready, req1_ready},
               mem_address, mem_write_data);
    end
    req0_read(10'h010, got);
    checks++;
    if (got !== 32'hC0DE0010) begin
      errors++; $display("FAIL abort_old_data: got %h want c0de0010", got);
    end
  endtask

  task automatic test_single_requester();
    int n;
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h002;
    for (int i = 0; i < 3; i++) begin
      #1;
      n = 0;
      while (!req1_ready && n < 10) begin @(negedge clk); #1; n++; end
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || n != ((i == 0) ? 0 : 3)) begin
        errors++;
        $display("FAIL solo_grant%0d: ready1 %b ready0 %b wait %0d want 1 0 %0d",
                 i, req1_ready, req0_ready, n, (i == 0) ? 0 : 3);
      end
      @(negedge clk);
    end
    req1_valid = 1'b0;
    n = 0;
    #1;
    while (busy && n < 10) begin @(negedge clk); #1; n++; end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] got;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h020; req0_wdata = 32'h00001000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n = 0;
      while (!req0_ready && n < 10) begin @(negedge clk); #1; n++; end
      checks++;
      if (req0_ready !== 1'b1 || n != ((i == 0) ? 0 : 2)) begin
        errors++;
        $display("FAIL b2b_wr%0d: ready0 %b wait %0d want 1 %0d", i, req0_ready, n, (i == 0) ? 0 : 2);
      end
      @(negedge clk);
      if (i == 2) begin
        req0_valid = 1'b0;
      end else begin
        req0_addr  = 10'h021 + 10'(i);
        req0_wdata = 32'h00001001 + 32'(i);
      end
    end
    n = 0;
    #1;
    while (busy && n < 10) begin @(negedge clk); #1; n++; end
    req0_read(10'h022, got);
    checks++;
    if (got !== 32'h00001002) begin
      errors++; $display("FAIL b2b_readback: got %h want 00001002", got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    test_single_requester();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
